core_wb_ctrl: RTL and testbench

Writeback controller that drives the register file's forward ports, write port and read-latch input from the memory/writeback pipeline. It captures execute-stage results, holds loads until data-bus read data returns, aligns and sign-extends load data, and stalls the front of the pipeline while a load is outstanding. It sits between the execute stage, the data-bus response channel and `core_regfile`.

---
 rtl/core_wb_ctrl.sv | 178 +++++++++++++++++
 tb/tb_core_wb_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/core_wb_ctrl.sv
// Memory/writeback controller feeding the regfile forward ports, write port and read latch.
// Optional misaligned-load trap: define CORE_WB_MISALIGN_EN.
module core_wb_ctrl #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_ex_valid,
   input  logic        i_ex_wen,
   input  logic        i_ex_is_load,
   input  logic [2:0]  i_ex_funct3,
   input  logic [4:0]  i_ex_rd,
   input  logic [31:0] i_ex_data,
   input  logic        i_dbus_rvalid,
   input  logic [31:0] i_dbus_rdata,
   output logic        o_stall,
   output logic        o_fwd1_en,
   output logic [4:0]  o_fwd1_addr,
   output logic [31:0] o_fwd1_data,
   output logic        o_fwd2_en,
   output logic [4:0]  o_fwd2_addr,
   output logic [31:0] o_fwd2_data,
   output logic        o_we,
   output logic [4:0]  o_waddr,
   output logic [31:0] o_wdata,
   output logic        o_bus_err,
   output logic        o_misalign
);

   typedef enum logic [1:0] {M_EMPTY, M_FULL, M_LOAD_WAIT} m_state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

   m_state_t    m_state_reg, m_state_next;
   logic [4:0]  m_rd_reg, m_rd_next;
   logic        m_wen_reg, m_wen_next;
   logic [31:0] m_data_reg, m_data_next;
   logic [2:0]  m_funct3_reg, m_funct3_next;
   logic        w_en_reg, w_en_next;
   logic [4:0]  w_rd_reg, w_rd_next;
   logic [31:0] w_data_reg, w_data_next;
   logic [15:0] cnt_reg, cnt_next;
   logic        bus_err_reg, bus_err_next;
   logic        misalign_reg, misalign_next;

   logic        accept;
   logic        m_writes;
   logic        load_mis;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_data;

   assign o_stall  = (m_state_reg == M_LOAD_WAIT);
   assign accept   = i_ex_valid & ~o_stall;
   assign m_writes = m_wen_reg & (m_rd_reg != 5'd0);

   // Load alignment: byte lane from addr[1:0], half lane from addr[1].
   always_comb begin
      byte_sel = i_dbus_rdata[{m_data_reg[1:0], 3'b000} +: 8];
      half_sel = m_data_reg[1] ? i_dbus_rdata[31:16] : i_dbus_rdata[15:0];
      case (m_funct3_reg)
         3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
         3'b100:  load_data = {24'd0, byte_sel};
         3'b101:  load_data = {16'd0, half_sel};
         default: load_data = i_dbus_rdata;
      endcase
   end

`ifdef CORE_WB_MISALIGN_EN
   always_comb begin
      case (m_funct3_reg)
         3'b000, 3'b100: load_mis = 1'b0;
         3'b001, 3'b101: load_mis = m_data_reg[0];
         default:        load_mis = |m_data_reg[1:0];
      endcase
   end
`else
   assign load_mis = 1'b0;
`endif

   always_comb begin
      m_state_next  = m_state_reg;
      m_rd_next     = m_rd_reg;
      m_wen_next    = m_wen_reg;
      m_data_next   = m_data_reg;
      m_funct3_next = m_funct3_reg;
      w_en_next     = 1'b0;
      w_rd_next     = 5'd0;
      w_data_next   = 32'd0;
      cnt_next      = cnt_reg;
      bus_err_next  = 1'b0;
      misalign_next = 1'b0;

      case (m_state_reg)
         M_FULL: begin
            m_state_next = M_EMPTY;
            if (m_writes) begin
               w_en_next   = 1'b1;
               w_rd_next   = m_rd_reg;
               w_data_next = m_data_reg;
            end
         end
         M_LOAD_WAIT: begin
            // Returning data takes priority over a timeout in the same cycle.
            if (i_dbus_rvalid) begin
               m_state_next = M_EMPTY;
               if (load_mis) begin
                  misalign_next = 1'b1;
               end else if (m_writes) begin
                  w_en_next   = 1'b1;
                  w_rd_next   = m_rd_reg;
                  w_data_next = load_data;
               end
            end else if (cnt_reg == TO_LAST) begin
               m_state_next = M_EMPTY;
               bus_err_next = 1'b1;
            end else begin
               cnt_next = cnt_reg + 16'd1;
            end
         end
         default: ;
      endcase

      if (accept) begin
         m_state_next  = i_ex_is_load ? M_LOAD_WAIT : M_FULL;
         m_rd_next     = i_ex_rd;
         m_wen_next    = i_ex_wen;
         m_data_next   = i_ex_data;
         m_funct3_next = i_ex_funct3;
         cnt_next      = 16'd0;
      end else if (m_state_reg == M_FULL) begin
         m_state_next = M_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state_reg  <= M_EMPTY;
         m_rd_reg     <= 5'd0;
         m_wen_reg    <= 1'b0;
         m_data_reg   <= 32'd0;
         m_funct3_reg <= 3'd0;
         w_en_reg     <= 1'b0;
         w_rd_reg     <= 5'd0;
         w_data_reg   <= 32'd0;
         cnt_reg      <= 16'd0;
         bus_err_reg  <= 1'b0;
         misalign_reg <= 1'b0;
      end else begin
         m_state_reg  <= m_state_next;
         m_rd_reg     <= m_rd_next;
         m_wen_reg    <= m_wen_next;
         m_data_reg   <= m_data_next;
         m_funct3_reg <= m_funct3_next;
         w_en_reg     <= w_en_next;
         w_rd_reg     <= w_rd_next;
         w_data_reg   <= w_data_next;
         cnt_reg      <= cnt_next;
         bus_err_reg  <= bus_err_next;
         misalign_reg <= misalign_next;
      end
   end

   // Loads never forward from M; only a held ALU result does.
   assign o_fwd1_en   = (m_state_reg == M_FULL) & m_writes;
   assign o_fwd1_addr = o_fwd1_en ? m_rd_reg : 5'd0;
   assign o_fwd1_data = o_fwd1_en ? m_data_reg : 32'd0;
   assign o_fwd2_en   = w_en_reg;
   assign o_fwd2_addr = w_rd_reg;
   assign o_fwd2_data = w_data_reg;
   assign o_we        = w_en_reg;
   assign o_waddr     = w_rd_reg;
   assign o_wdata     = w_data_reg;
   assign o_bus_err   = bus_err_reg;
   assign o_misalign  = misalign_reg;

endmodule

// File: tb/tb_core_wb_ctrl.sv
// Directed self-checking bench for core_wb_ctrl (built with TIMEOUT_CYC=4).
module tb_core_wb_ctrl;

`ifdef CORE_WB_MISALIGN_EN
   localparam bit MIS_ON = 1'b1;
`else
   localparam bit MIS_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex_valid = 1'b0, ex_wen = 1'b0, ex_is_load = 1'b0;
   logic [2:0]  ex_funct3 = 3'd0;
   logic [4:0]  ex_rd = 5'd0;
   logic [31:0] ex_data = 32'd0;
   logic        dbus_rvalid = 1'b0;
   logic [31:0] dbus_rdata = 32'd0;
   logic        o_stall, o_fwd1_en, o_fwd2_en, o_we, o_bus_err, o_misalign;
   logic [4:0]  o_fwd1_addr, o_fwd2_addr, o_waddr;
   logic [31:0] o_fwd1_data, o_fwd2_data, o_wdata;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   core_wb_ctrl #(.TIMEOUT_CYC(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_ex_valid(ex_valid), .i_ex_wen(ex_wen), .i_ex_is_load(ex_is_load),
      .i_ex_funct3(ex_funct3), .i_ex_rd(ex_rd), .i_ex_data(ex_data),
      .i_dbus_rvalid(dbus_rvalid), .i_dbus_rdata(dbus_rdata),
      .o_stall(o_stall),
      .o_fwd1_en(o_fwd1_en), .o_fwd1_addr(o_fwd1_addr), .o_fwd1_data(o_fwd1_data),
      .o_fwd2_en(o_fwd2_en), .o_fwd2_addr(o_fwd2_addr), .o_fwd2_data(o_fwd2_data),
      .o_we(o_we), .o_waddr(o_waddr), .o_wdata(o_wdata),
      .o_bus_err(o_bus_err), .o_misalign(o_misalign)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_stall"}, 32'(o_stall), 32'd0);
      chk({tag, "_fwd1en"}, 32'(o_fwd1_en), 32'd0);
      chk({tag, "_fwd2en"}, 32'(o_fwd2_en), 32'd0);
      chk({tag, "_we"}, 32'(o_we), 32'd0);
      chk({tag, "_waddr"}, 32'(o_waddr), 32'd0);
      chk({tag, "_wdata"}, o_wdata, 32'd0);
      chk({tag, "_fwd1d"}, o_fwd1_data, 32'd0);
      chk({tag, "_fwd2d"}, o_fwd2_data, 32'd0);
      chk({tag, "_buserr"}, 32'(o_bus_err), 32'd0);
      chk({tag, "_mis"}, 32'(o_misalign), 32'd0);
   endtask

   task automatic drive_alu(input logic [4:0] rd, input logic [31:0] d);
      ex_valid = 1'b1; ex_wen = 1'b1; ex_is_load = 1'b0;
      ex_funct3 = 3'd0; ex_rd = rd; ex_data = d;
   endtask

   // Load accepted at the next edge; rvalid arrives in the lat-th stalled cycle.
   task automatic do_load(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] addr, input logic [31:0] rdata, input int lat,
                          input logic [31:0] exp_d, input bit mis);
      ex_valid = 1'b1; ex_wen = 1'b1; ex_is_load = 1'b1;
      ex_funct3 = f3; ex_rd = rd; ex_data = addr;
      tick();
      ex_valid = 1'b0; ex_is_load = 1'b0;
      for (int i = 1; i <= lat; i++) begin
         if (i == lat) begin
            dbus_rvalid = 1'b1; dbus_rdata = rdata;
         end
         chk({tag, "_stall_wait"}, 32'(o_stall), 32'd1);
         chk({tag, "_we_wait"}, 32'(o_we), 32'd0);
         tick();
      end
      dbus_rvalid = 1'b0;
      chk({tag, "_stall_done"}, 32'(o_stall), 32'd0);
      if (MIS_ON && mis) begin
         chk({tag, "_we_mis"}, 32'(o_we), 32'd0);
         chk({tag, "_mis"}, 32'(o_misalign), 32'd1);
      end else begin
         chk({tag, "_we"}, 32'(o_we), 32'd1);
         chk({tag, "_waddr"}, 32'(o_waddr), 32'(rd));
         chk({tag, "_wdata"}, o_wdata, exp_d);
         chk({tag, "_fwd2d"}, o_fwd2_data, exp_d);
         chk({tag, "_fwd1en"}, 32'(o_fwd1_en), 32'd0);
         chk({tag, "_mis0"}, 32'(o_misalign), 32'd0);
      end
      tick();
      chk({tag, "_we_after"}, 32'(o_we), 32'd0);
      chk({tag, "_mis_after"}, 32'(o_misalign), 32'd0);
   endtask

   initial begin
      // Reset
      #1;
      chk_idle("rst");
      tick();
      tick();
      rst_n = 1'b1;
      chk_idle("post_rst");

      // Single ALU op, rd=5
      drive_alu(5'd5, 32'h1234_5678);
      tick();
      ex_valid = 1'b0;
      chk("alu_c1_fwd1en", 32'(o_fwd1_en), 32'd1);
      chk("alu_c1_fwd1a", 32'(o_fwd1_addr), 32'd5);
      chk("alu_c1_fwd1d", o_fwd1_data, 32'h1234_5678);
      chk("alu_c1_we", 32'(o_we), 32'd0);
      tick();
      chk("alu_c2_fwd1en", 32'(o_fwd1_en), 32'd0);
      chk("alu_c2_fwd2en", 32'(o_fwd2_en), 32'd1);
      chk("alu_c2_fwd2a", 32'(o_fwd2_addr), 32'd5);
      chk("alu_c2_fwd2d", o_fwd2_data, 32'h1234_5678);
      chk("alu_c2_we", 32'(o_we), 32'd1);
      chk("alu_c2_waddr", 32'(o_waddr), 32'd5);
      chk("alu_c2_wdata", o_wdata, 32'h1234_5678);
      tick();
      chk("alu_c3_we", 32'(o_we), 32'd0);
      chk("alu_c3_fwd2en", 32'(o_fwd2_en), 32'd0);

      // Back-to-back ALU ops: one write per cycle
      drive_alu(5'd1, 32'h0000_0011);
      tick();
      drive_alu(5'd2, 32'h0000_0022);
      chk("b2b_fwd1a_1", 32'(o_fwd1_addr), 32'd1);
      tick();
      drive_alu(5'd3, 32'h0000_0033);
      chk("b2b_fwd1a_2", 32'(o_fwd1_addr), 32'd2);
      chk("b2b_waddr_1", 32'(o_waddr), 32'd1);
      chk("b2b_wdata_1", o_wdata, 32'h0000_0011);
      tick();
      ex_valid = 1'b0;
      chk("b2b_fwd1a_3", 32'(o_fwd1_addr), 32'd3);
      chk("b2b_we_2", 32'(o_we), 32'd1);
      chk("b2b_wdata_2", o_wdata, 32'h0000_0022);
      tick();
      chk("b2b_we_3", 32'(o_we), 32'd1);
      chk("b2b_wdata_3", o_wdata, 32'h0000_0033);
      tick();
      chk("b2b_we_end", 32'(o_we), 32'd0);

      // rd=0 never writes or forwards
      drive_alu(5'd0, 32'hFFFF_FFFF);
      tick();
      ex_valid = 1'b0;
      chk("rd0_fwd1en", 32'(o_fwd1_en), 32'd0);
      tick();
      chk("rd0_fwd2en", 32'(o_fwd2_en), 32'd0);
      chk("rd0_we", 32'(o_we), 32'd0);
      tick();

      // Loads: sign/zero extension and lane selection
      do_load("lb", 3'b000, 5'd3, 32'h0000_1001, 32'h0000_8000, 4, 32'hFFFF_FF80, 1'b0);
      do_load("lbu", 3'b100, 5'd3, 32'h0000_1001, 32'h0000_8000, 4, 32'h0000_0080, 1'b0);
      do_load("lh_mis", 3'b001, 5'd7, 32'h0000_2003, 32'h8765_4321, 1, 32'hFFFF_8765, 1'b1);
      do_load("lhu", 3'b101, 5'd8, 32'h0000_2002, 32'h8001_1234, 2, 32'h0000_8001, 1'b0);
      do_load("lw", 3'b010, 5'd9, 32'h0000_2000, 32'hCAFE_F00D, 3, 32'hCAFE_F00D, 1'b0);
      do_load("lb3", 3'b000, 5'd10, 32'h0000_2003, 32'h7F00_0000, 1, 32'h0000_007F, 1'b0);

      // Timeout: 4 stalled cycles, one bus_err pulse, no write, stray rvalid ignored
      ex_valid = 1'b1; ex_wen = 1'b1; ex_is_load = 1'b1;
      ex_funct3 = 3'b010; ex_rd = 5'd4; ex_data = 32'h0000_3000;
      tick();
      ex_valid = 1'b0; ex_is_load = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         chk("to_stall", 32'(o_stall), 32'd1);
         chk("to_buserr_wait", 32'(o_bus_err), 32'd0);
         tick();
      end
      chk("to_stall_end", 32'(o_stall), 32'd0);
      chk("to_buserr", 32'(o_bus_err), 32'd1);
      chk("to_we", 32'(o_we), 32'd0);
      tick();
      chk("to_buserr_clr", 32'(o_bus_err), 32'd0);
      dbus_rvalid = 1'b1; dbus_rdata = 32'h0000_0055;
      tick();
      dbus_rvalid = 1'b0;
      chk("stray_we", 32'(o_we), 32'd0);
      chk("stray_fwd2en", 32'(o_fwd2_en), 32'd0);
      tick();

      // Reset during LOAD_WAIT, then a late rvalid
      ex_valid = 1'b1; ex_wen = 1'b1; ex_is_load = 1'b1;
      ex_funct3 = 3'b010; ex_rd = 5'd6; ex_data = 32'h0000_4000;
      tick();
      ex_valid = 1'b0; ex_is_load = 1'b0;
      tick();
      chk("rstmid_stall_pre", 32'(o_stall), 32'd1);
      rst_n = 1'b0;
      #1;
      chk_idle("rstmid");
      tick();
      rst_n = 1'b1;
      dbus_rvalid = 1'b1; dbus_rdata = 32'hDEAD_BEEF;
      tick();
      dbus_rvalid = 1'b0;
      chk_idle("late_rvalid");
      tick();
      chk("late_rvalid_we2", 32'(o_we), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
